mdu_seq: RTL
============

# mdu_seq

Iterative multiply/divide unit that sits directly downstream of the register file read ports and upstream of its write port. It captures two operands from `rdata1`/`rdata2` on `start` and runs a 32-step shift-add multiply or restoring divide. It then issues a single-cycle write-back (`wb_we`/`wb_waddr`/`wb_wdata`) that drives the register file's `we`/`waddr`/`wdata` directly. Operands are captured internally, so the read ports are free once `start` has been accepted.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width. The step counter is `$clog2(WIDTH)+1` bits.

Ports:
- `CLK`  in  1  clock; all state updates on rising edge.
- `RST_n`  in  1  reset; asynchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  0 = MULU (low product), 1 = MULHU (high product), 2 = DIVU (quotient), 3 = REMU (remainder).
- `src_a`  in  WIDTH  multiplicand or dividend (from `rdata1`).
- `src_b`  in  WIDTH  multiplier or divisor (from `rdata2`).
- `dst`  in  5  destination register index.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse, coincident with `wb_we`.
- `wb_we`  out  1  register file write enable (one cycle).
- `wb_waddr`  out  5  write address (the captured `dst`).
- `wb_wdata`  out  WIDTH  result.

## Operation
- State machine IDLE -> RUN -> WB -> IDLE.
- **IDLE:**
  - When `start` = 1: latch `op`, `src_a`, `src_b` and `dst`; clear the accumulator; set count = 0; go to RUN.
  - When `start` = 0: stay in IDLE.
- **RUN:** exactly WIDTH iterations, one per cycle. Increment count each cycle; at count = WIDTH-1, go to WB.
  - Multiply (ops 0/1): 2·WIDTH-bit product register, shift-add LSB-first over the multiplier.
  - Divide (ops 2/3): restoring divide.
    - Each step: remainder = {remainder, dividend MSB}.
    - If remainder ≥ divisor: subtract the divisor and shift in 1; otherwise shift in 0.
    - Compare and subtract at WIDTH+1 bits; no overflow is possible.
- **Divide by zero:** requires no special case. The algorithm yields quotient 0xFFFFFFFF and remainder = dividend, and these are the required results.
- **WB:**
  - `wb_we` = 1 and `done` = 1.
  - `wb_wdata` is selected by the latched op; `wb_waddr` = latched `dst`.
  - Next state is IDLE.
- `dst` = 0 is written like any other index. Register-0 policy belongs to the register file.
- `start` in RUN or WB is ignored and not queued.
- `wb_waddr`/`wb_wdata` hold their last values outside WB. Only `wb_we` qualifies them.

## Timing
- Reset (asynchronous, any cycle, including mid-RUN):
  - state = IDLE; count = 0.
  - `busy`, `done`, `wb_we` = 0.
  - `wb_waddr` = 0, `wb_wdata` = 0; internal registers cleared.
  - The in-flight operation is discarded and no write-back occurs.
- Latency, with `start` sampled at edge k:
  - RUN occupies edges k+1 .. k+WIDTH.
  - WB is the cycle after edge k+WIDTH; `wb_we` is high for exactly that one cycle, 33 cycles after acceptance.
- `busy` is high for WIDTH+1 = 33 cycles and drops the cycle after WB.
- Back-to-back: the next `start` is accepted at the first edge in IDLE. Throughput is one operation per 34 cycles.
- The register file writes on the falling edge. The `wb_*` outputs are registered on the rising edge, which gives half a cycle of setup before the falling-edge capture.
- All outputs are registered (Moore). There are no combinational paths from inputs to outputs.

## Structure
- Shared package `mdu_pkg` holds:
  - the op encodings (`MDU_MULU`, `MDU_MULHU`, `MDU_DIVU`, `MDU_REMU`);
  - the state encodings (IDLE = 0, RUN = 1, WB = 2);
  - `MDU_WIDTH` = 32.
- One sub-module is natural: `mdu_step`, the combinational single-iteration datapath (shift-add step or restore step, selected by op class). The FSM, counter and output registers stay in `mdu_seq`.

## Test plan
1. MULU, 0x0000FFFF × 0x00010001, `dst` = 5 → `wb_we` exactly 33 cycles after `start`, with `wb_waddr` = 5 and `wb_wdata` = 0xFFFFFFFF.
2. MULHU, 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; a repeat with MULU → 0x00000001.
3. DIVU 100 / 7 → 14; REMU 100 / 7 → 2; these two run back-to-back, with the second `start` on the first IDLE cycle after WB.
4. Divide by zero on 0x12345678: DIVU → 0xFFFFFFFF; REMU → 0x12345678.
5. Assert `start` with different operands during RUN and during WB → ignored; the result matches the first operation and exactly one `wb_we` pulse occurs.
6. Assert `RST_n` at RUN step 10 → all outputs are 0 immediately and no `wb_we` follows. After release, a new MULU 3 × 4 → 12 with normal latency.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings and sizing for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULU  = 2'd0,
    MDU_MULHU = 2'd1,
    MDU_DIVU  = 2'd2,
    MDU_REMU  = 2'd3
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_WB   = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_ext;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Multiply: acc = {partial, multiplier}, add multiplicand on LSB then shift right.
  // Divide:   acc = {remainder, dividend/quotient}, shift left and restore.
  always_comb begin
    sum     = '0;
    rem_ext = '0;
    diff    = '0;
    ge      = 1'b0;
    acc_o   = '0;
    if (is_div_i) begin
      rem_ext = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
      ge      = (rem_ext >= {1'b0, opnd_i});
      // When ge holds the true difference is below the divisor, so WIDTH bits suffice.
      diff    = rem_ext[WIDTH-1:0] - opnd_i;
      acc_o   = {(ge ? diff : rem_ext[WIDTH-1:0]), acc_i[WIDTH-2:0], ge};
    end else begin
      sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} +
              (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit: capture operands, iterate WIDTH steps,
// then issue a single-cycle register file write-back.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [4:0]       dst,
  output logic             busy,
  output logic             done,
  output logic             wb_we,
  output logic [4:0]       wb_waddr,
  output logic [WIDTH-1:0] wb_wdata
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  mdu_state_e         state_q;
  mdu_op_e            op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   opnd_q;
  logic [4:0]         dst_q;
  logic               is_div;
  logic               sel_hi;

  assign is_div = (op_q == MDU_DIVU) || (op_q == MDU_REMU);
  assign sel_hi = (op_q == MDU_MULHU) || (op_q == MDU_REMU);

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_d)
  );

  // Reset input is active-high despite its name.
  always_ff @(posedge CLK or posedge RST_n) begin
    if (RST_n) begin
      state_q  <= MDU_IDLE;
      op_q     <= MDU_MULU;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      dst_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wb_we    <= 1'b0;
      wb_waddr <= '0;
      wb_wdata <= '0;
    end else begin
      done  <= 1'b0;
      wb_we <= 1'b0;
      case (state_q)
        MDU_IDLE: begin
          if (start) begin
            op_q    <= mdu_op_e'(op);
            dst_q   <= dst;
            // Low half of acc holds the multiplier or the dividend; opnd the other.
            acc_q   <= {{WIDTH{1'b0}}, (op[1] ? src_a : src_b)};
            opnd_q  <= op[1] ? src_b : src_a;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= MDU_RUN;
          end
        end
        MDU_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q  <= MDU_WB;
            wb_we    <= 1'b1;
            done     <= 1'b1;
            wb_waddr <= dst_q;
            wb_wdata <= sel_hi ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];
          end
        end
        MDU_WB: begin
          busy    <= 1'b0;
          state_q <= MDU_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= MDU_IDLE;
        end
      endcase
    end
  end

endmodule
